// File: rtl/cf_fft_1024_8_seq_if.sv
// Control/address bundle between FFT start/done control, data RAM, twiddle ROM and the sequencer.
interface cf_fft_1024_8_seq_if #(
    parameter int LOG2N = 10
);
    logic             start_i;
    logic             hold_i;
    logic             busy_o;
    logic             done_o;
    logic [3:0]       stage_o;
    logic             rd_en_o;
    logic [LOG2N-1:0] rd_addr_a_o;
    logic [LOG2N-1:0] rd_addr_b_o;
    logic [LOG2N-2:0] tw_idx_o;
    logic             wr_en_o;
    logic [LOG2N-1:0] wr_addr_a_o;
    logic [LOG2N-1:0] wr_addr_b_o;

    modport master (
        output start_i, hold_i,
        input  busy_o, done_o, stage_o,
        input  rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
        input  wr_en_o, wr_addr_a_o, wr_addr_b_o
    );

    modport slave (
        input  start_i, hold_i,
        output busy_o, done_o, stage_o,
        output rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
        output wr_en_o, wr_addr_a_o, wr_addr_b_o
    );
endinterface

// File: rtl/cf_fft_1024_8_seq.sv
// Radix-2 DIF stage/butterfly sequencer: read A/B + twiddle per butterfly, write-back delayed.
// Latency: first read 1 cycle after start accept; writes trail reads by BFLY_LAT cycles.
// Backpressure: hold_i freezes read issue in RUN; the write delay line keeps shifting.
module cf_fft_1024_8_seq #(
    parameter int LOG2N    = 10,
    parameter int BFLY_LAT = 3
) (
    input  logic               clock_c,
    input  logic               reset_n,
    cf_fft_1024_8_seq_if.slave bus
);
    localparam int AW = LOG2N;
    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(BFLY_LAT + 1);
    localparam logic [3:0]    LAST_STAGE = 4'(LOG2N - 1);
    localparam logic [KW-1:0] LAST_K     = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q;
    logic [3:0]     stage_q;
    logic [KW-1:0]  k_q;
    logic [DW-1:0]  drain_q;
    logic           busy_q;
    logic           done_q;
    logic           rd_en_q;
    logic [AW-1:0]  rd_addr_a_q;
    logic [AW-1:0]  rd_addr_b_q;
    logic [KW-1:0]  tw_idx_q;

    logic [AW-1:0]  span_d;
    logic [AW-1:0]  mask_d;
    logic [AW-1:0]  k_ext_d;
    logic [AW-1:0]  idx_d;
    logic [AW-1:0]  rd_addr_a_d;
    logic [AW-1:0]  rd_addr_b_d;
    logic [KW-1:0]  tw_idx_d;

    // Group bits of k move up one position to open the span bit; B is A with that bit set.
    always_comb begin
        span_d      = {1'b1, {KW{1'b0}}} >> stage_q;
        mask_d      = span_d - AW'(1);
        k_ext_d     = {1'b0, k_q};
        idx_d       = k_ext_d & mask_d;
        rd_addr_a_d = ((k_ext_d & ~mask_d) << 1) | idx_d;
        rd_addr_b_d = rd_addr_a_d | span_d;
        tw_idx_d    = KW'(idx_d << stage_q);
    end

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            k_q         <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_idx_q    <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start_i) begin
                        state_q <= RUN;
                        stage_q <= '0;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    busy_q <= 1'b1;
                    if (!bus.hold_i) begin
                        rd_en_q     <= 1'b1;
                        rd_addr_a_q <= rd_addr_a_d;
                        rd_addr_b_q <= rd_addr_b_d;
                        tw_idx_q    <= tw_idx_d;
                        k_q         <= k_q + KW'(1);
                        if (k_q == LAST_K) begin
                            state_q <= DRAIN;
                            drain_q <= DW'(BFLY_LAT);
                        end
                    end
                end
                DRAIN: begin
                    // Waiting out the pipeline keeps the next stage's reads behind this stage's writes.
                    busy_q <= 1'b1;
                    if (drain_q == DW'(1)) begin
                        if (stage_q == LAST_STAGE) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= RUN;
                            stage_q <= stage_q + 4'd1;
                            k_q     <= '0;
                        end
                    end
                    drain_q <= drain_q - DW'(1);
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    logic [BFLY_LAT-1:0] wr_en_pipe_q;
    logic [AW-1:0]       wr_a_pipe_q [BFLY_LAT];
    logic [AW-1:0]       wr_b_pipe_q [BFLY_LAT];

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_pipe_q <= '0;
            for (int i = 0; i < BFLY_LAT; i++) begin
                wr_a_pipe_q[i] <= '0;
                wr_b_pipe_q[i] <= '0;
            end
        end else begin
            wr_en_pipe_q[0] <= rd_en_q;
            wr_a_pipe_q[0]  <= rd_addr_a_q;
            wr_b_pipe_q[0]  <= rd_addr_b_q;
            for (int i = 1; i < BFLY_LAT; i++) begin
                wr_en_pipe_q[i] <= wr_en_pipe_q[i-1];
                wr_a_pipe_q[i]  <= wr_a_pipe_q[i-1];
                wr_b_pipe_q[i]  <= wr_b_pipe_q[i-1];
            end
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.stage_o     = stage_q;
    assign bus.rd_en_o     = rd_en_q;
    assign bus.rd_addr_a_o = rd_addr_a_q;
    assign bus.rd_addr_b_o = rd_addr_b_q;
    assign bus.tw_idx_o    = tw_idx_q;
    assign bus.wr_en_o     = wr_en_pipe_q[BFLY_LAT-1];
    assign bus.wr_addr_a_o = wr_a_pipe_q[BFLY_LAT-1];
    assign bus.wr_addr_b_o = wr_b_pipe_q[BFLY_LAT-1];
endmodule

// File: tb/tb_cf_fft_1024_8_seq.sv
// Scoreboard bench for the FFT stage/butterfly sequencer: expected reads, writes and done
// are queued by the stimulus and consumed by a negedge monitor.
module tb_cf_fft_1024_8_seq;
    localparam int LAT       = 3;
    localparam int STAGE_CYC = 512 + LAT;

    logic clock_c = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   tests   = 0;
    int   failed  = 0;

    typedef struct { int cyc; int stage; int a; int b; int tw; } rd_t;
    typedef struct { int cyc; int a; int b; } wr_t;
    typedef struct { int cyc; int busy; } done_t;
    typedef struct { int s; int k; int a; int b; int tw; } spot_t;

    rd_t   exp_rd_q[$];
    wr_t   exp_wr_q[$];
    done_t exp_done_q[$];
    spot_t spots[4];

    int rd_tr, wr_tr, busy_cnt;
    int rd_total = 0;
    int wr_total = 0;
    int rd_hits[1024];
    int wr_hits[1024];

    cf_fft_1024_8_seq_if bus ();

    cf_fft_1024_8_seq #(.LOG2N(10), .BFLY_LAT(LAT)) dut (
        .clock_c (clock_c),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock_c = ~clock_c;
    always @(posedge clock_c) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Straight from the butterfly definition: group, offset within group, span.
    function automatic rd_t model_rd(input int c, input int s, input int k);
        rd_t r;
        int span, grp, idx;
        span    = 512 >> s;
        grp     = k >> (9 - s);
        idx     = k % span;
        r.cyc   = c;
        r.stage = s;
        r.a     = grp * (2 * span) + idx;
        r.b     = r.a + span;
        r.tw    = (idx << s) % 512;
        return r;
    endfunction

    task automatic push_transform(input int t0, input int hold_s, input int hold_k, input int hold_len);
        int    extra;
        done_t d;
        for (int s = 0; s < 10; s++) begin
            for (int k = 0; k < 512; k++) begin
                extra = ((s > hold_s) || (s == hold_s && k >= hold_k)) ? hold_len : 0;
                exp_rd_q.push_back(model_rd(t0 + 1 + s * STAGE_CYC + k + extra, s, k));
            end
        end
        d.cyc  = t0 + 10 * STAGE_CYC + 1 + hold_len;
        d.busy = 10 * STAGE_CYC + hold_len;
        exp_done_q.push_back(d);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock_c);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  bus.busy_o, 0);
        check({tag, "_done"},  bus.done_o, 0);
        check({tag, "_stage"}, bus.stage_o, 0);
        check({tag, "_rd_en"}, bus.rd_en_o, 0);
        check({tag, "_rd_a"},  bus.rd_addr_a_o, 0);
        check({tag, "_rd_b"},  bus.rd_addr_b_o, 0);
        check({tag, "_tw"},    bus.tw_idx_o, 0);
        check({tag, "_wr_en"}, bus.wr_en_o, 0);
        check({tag, "_wr_a"},  bus.wr_addr_a_o, 0);
        check({tag, "_wr_b"},  bus.wr_addr_b_o, 0);
    endtask

    always @(negedge clock_c) begin
        rd_t   e;
        wr_t   w;
        done_t d;
        int    a, b, bad;
        if (!reset_n) begin
            exp_rd_q.delete();
            exp_wr_q.delete();
            exp_done_q.delete();
            rd_tr    = 0;
            wr_tr    = 0;
            busy_cnt = 0;
            foreach (rd_hits[i]) begin
                rd_hits[i] = 0;
                wr_hits[i] = 0;
            end
        end else begin
            if (bus.busy_o) busy_cnt++;
            if (bus.wr_en_o) begin
                a = int'(bus.wr_addr_a_o);
                b = int'(bus.wr_addr_b_o);
                check("wr_expected", int'(exp_wr_q.size() > 0), 1);
                if (exp_wr_q.size() > 0) begin
                    w = exp_wr_q.pop_front();
                    check("wr_cycle", cyc, w.cyc);
                    check("wr_addr_a", a, w.a);
                    check("wr_addr_b", b, w.b);
                end
                wr_hits[a]++;
                wr_hits[b]++;
                wr_tr++;
                wr_total++;
                if (wr_tr % 512 == 0) begin
                    bad = 0;
                    foreach (wr_hits[i]) begin
                        if (wr_hits[i] != 1) bad++;
                        wr_hits[i] = 0;
                    end
                    check("wr_stage_cover", bad, 0);
                end
            end
            if (bus.rd_en_o) begin
                a = int'(bus.rd_addr_a_o);
                b = int'(bus.rd_addr_b_o);
                check("rd_expected", int'(exp_rd_q.size() > 0), 1);
                if (exp_rd_q.size() > 0) begin
                    e = exp_rd_q.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_stage", bus.stage_o, e.stage);
                    check("rd_addr_a", a, e.a);
                    check("rd_addr_b", b, e.b);
                    check("rd_tw", bus.tw_idx_o, e.tw);
                end
                foreach (spots[j]) begin
                    if (rd_tr == spots[j].s * 512 + spots[j].k) begin
                        check("spot_a", a, spots[j].a);
                        check("spot_b", b, spots[j].b);
                        check("spot_tw", bus.tw_idx_o, spots[j].tw);
                    end
                end
                if (rd_tr % 512 == 0 && rd_tr > 0)
                    check("raw_order", int'(wr_tr >= rd_tr), 1);
                rd_hits[a]++;
                rd_hits[b]++;
                rd_tr++;
                rd_total++;
                if (rd_tr % 512 == 0) begin
                    bad = 0;
                    foreach (rd_hits[i]) begin
                        if (rd_hits[i] != 1) bad++;
                        rd_hits[i] = 0;
                    end
                    check("rd_stage_cover", bad, 0);
                end
                w.cyc = cyc + LAT;
                w.a   = a;
                w.b   = b;
                exp_wr_q.push_back(w);
            end
            if (bus.done_o) begin
                check("done_expected", int'(exp_done_q.size() > 0), 1);
                if (exp_done_q.size() > 0) begin
                    d = exp_done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("busy_cycles", busy_cnt, d.busy);
                end
                check("busy_at_done", bus.busy_o, 0);
                check("rd_pulses", rd_tr, 5120);
                check("wr_pulses", wr_tr, 5120);
                rd_tr    = 0;
                wr_tr    = 0;
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, t2, r0, w0;
        spots = '{'{0, 5, 5, 517, 5}, '{3, 100, 164, 228, 288},
                  '{9, 5, 10, 11, 0}, '{4, 99, 195, 227, 48}};
        bus.start_i = 1'b0;
        bus.hold_i  = 1'b0;
        reset_n     = 1'b0;
        repeat (3) @(negedge clock_c);
        check_zero("reset");
        reset_n = 1'b1;
        wait_until(cyc + 4);

        // Transform 1: single start pulse, stray starts in RUN and DRAIN.
        t0 = cyc + 1;
        push_transform(t0, -1, 0, 0);
        bus.start_i = 1'b1;
        wait_until(t0);
        bus.start_i = 1'b0;
        check("busy_at_accept", bus.busy_o, 0);
        wait_until(t0 + 1);
        check("busy_first", bus.busy_o, 1);
        wait_until(t0 + 299);
        bus.start_i = 1'b1;
        wait_until(t0 + 300);
        bus.start_i = 1'b0;
        wait_until(t0 + 513);
        bus.start_i = 1'b1;
        wait_until(t0 + 514);
        bus.start_i = 1'b0;

        // Transform 2: start held across done, then a 10-cycle hold in stage 4.
        wait_until(t0 + 5140);
        bus.start_i = 1'b1;
        t1 = t0 + 5152;
        push_transform(t1, 4, 100, 10);
        wait_until(t1);
        bus.start_i = 1'b0;
        wait_until(t1 + 2160);
        bus.hold_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wait_until(t1 + 2160 + i);
            check("hold_rd_en", bus.rd_en_o, 0);
            check("hold_addr_a", bus.rd_addr_a_o, 195);
            check("hold_addr_b", bus.rd_addr_b_o, 227);
            check("hold_tw", bus.tw_idx_o, 48);
        end
        bus.hold_i = 1'b0;

        // Transform 3: aborted by reset in stage 6.
        wait_until(t1 + 5170);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        t2 = cyc + 1;
        push_transform(t2, -1, 0, 0);
        bus.start_i = 1'b1;
        wait_until(t2);
        bus.start_i = 1'b0;
        wait_until(t2 + 3200);
        check("pre_reset_stage", bus.stage_o, 6);
        @(posedge clock_c);
        #2 reset_n = 1'b0;
        #1 check_zero("mid_reset");
        repeat (3) @(negedge clock_c);
        reset_n = 1'b1;
        r0 = rd_total;
        w0 = wr_total;
        repeat (40) @(negedge clock_c);
        check("post_reset_rd", rd_total, r0);
        check("post_reset_wr", wr_total, w0);
        check("post_reset_busy", bus.busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
